// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for regfile_sb.
// Default widths plus the pend_cnt step function.
package regfile_pkg;

   localparam int NBITS_DEF = 32;
   localparam int AW_DEF    = 5;
   localparam int NRD_DEF   = 2;

   // Signed pend_cnt step from this cycle's events.
   // clr: a busy register is released.
   // set: an idle register is reserved.
   // Result is +1 (2'b01), -1 (2'b11) or 0.
   function automatic logic [1:0] pend_step(
      input logic clr,
      input logic set
   );
      logic [1:0] s;
      s = 2'b00;
      unique case (1'b1)
         (set && !clr): s = 2'b01;
         (clr && !set): s = 2'b11;
         default:       s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy vector and pend_cnt.
// Ports: clk, rst_n, we/wa (release), rsv_en/rsv_addr
// (reserve), busy_vec (NREGS), pend_cnt (AW+1).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_addr,
   output logic [2**AW-1:0]  busy_vec,
   output logic [AW:0]       pend_cnt
);

   localparam int NREGS = 2**AW;

   logic              wr_hit;
   logic              rsv_hit;
   logic              clr_ev;
   logic              set_ev;
   logic [1:0]        step;
   logic [NREGS-1:0]  busy_nxt;
   logic [AW:0]       cnt_nxt;

   assign wr_hit  = we && (wa != '0);
   assign rsv_hit = rsv_en && (rsv_addr != '0);

   // A release only counts if the bit was set and a
   // same-address reservation does not keep it busy.
   assign clr_ev = wr_hit && busy_vec[wa]
                 && !(rsv_hit && (rsv_addr == wa));
   // A reservation only counts on an idle register.
   assign set_ev = rsv_hit && !busy_vec[rsv_addr];

   assign step    = pend_step(clr_ev, set_ev);
   assign cnt_nxt = pend_cnt
                  + {{(AW-1){step[1]}}, step};

   // Release first, reserve second: newer producer wins.
   always_comb begin
      busy_nxt = busy_vec;
      if (wr_hit)  busy_nxt[wa]       = 1'b0;
      if (rsv_hit) busy_nxt[rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec <= '0;
         pend_cnt <= '0;
      end else begin
         busy_vec <= busy_nxt;
         pend_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NRD-port register file with busy scoreboard.
// Ports: clk, rst_n, ra/rd/busy (reads), we/wa/wd (write),
// rsv_en/rsv_addr (reserve), pend_cnt (busy count).
// Option: REGFILE_BYPASS_EN forwards wd/busy to reads.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int AW    = AW_DEF,
   parameter int NRD   = NRD_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*NBITS-1:0] rd,
   output logic [NRD-1:0]       busy,
   input  logic                 we,
   input  logic [AW-1:0]        wa,
   input  logic [NBITS-1:0]     wd,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_addr,
   output logic [AW:0]          pend_cnt
);

   localparam int NREGS = 2**AW;

   logic [NBITS-1:0] mem [NREGS];
   logic [NREGS-1:0] busy_vec;
   logic [AW-1:0]    ra_a [NRD];

   regfile_scoreboard #(
      .AW (AW)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .wa       (wa),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec),
      .pend_cnt (pend_cnt)
   );

   // mem[0] is never written, so it stays at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_ra
      assign ra_a[g] = ra[g*AW +: AW];
   end

   always_comb begin
      rd   = '0;
      busy = '0;
      for (int i = 0; i < NRD; i++) begin
         rd[i*NBITS +: NBITS] = mem[ra_a[i]];
         busy[i]              = busy_vec[ra_a[i]];
`ifdef REGFILE_BYPASS_EN
         // In-flight write-back forwarded this cycle;
         // a same-cycle reservation re-marks it busy.
         if (we && (wa != '0) && (ra_a[i] == wa)) begin
            rd[i*NBITS +: NBITS] = wd;
            busy[i] = rsv_en && (rsv_addr == wa);
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb.
// Expected values are queued at drive time, popped on check.
module tb_regfile_sb;

   localparam int NBITS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b1;
   logic [NRD*AW-1:0]    ra;
   logic [NRD*NBITS-1:0] rd;
   logic [NRD-1:0]       busy;
   logic                 we;
   logic [AW-1:0]        wa;
   logic [NBITS-1:0]     wd;
   logic                 rsv_en;
   logic [AW-1:0]        rsv_addr;
   logic [AW:0]          pend_cnt;

   int n_run  = 0;
   int n_fail = 0;

   int          q_sel [$];
   string       q_tag [$];
   logic [63:0] q_exp [$];

   localparam int S_RD0  = 0;
   localparam int S_RD1  = 1;
   localparam int S_BUSY = 2;
   localparam int S_PEND = 3;

   regfile_sb #(
      .NBITS (NBITS),
      .AW    (AW),
      .NRD   (NRD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra       (ra),
      .rd       (rd),
      .busy     (busy),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .pend_cnt (pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [63:0] observe(input int sel);
      logic [63:0] v;
      v = '0;
      case (sel)
         S_RD0:   v = 64'(rd[31:0]);
         S_RD1:   v = 64'(rd[63:32]);
         S_BUSY:  v = 64'(busy);
         default: v = 64'(pend_cnt);
      endcase
      return v;
   endfunction

   task automatic push(
      input int          sel,
      input string       tag,
      input logic [63:0] v
   );
      q_sel.push_back(sel);
      q_tag.push_back(tag);
      q_exp.push_back(v);
   endtask

   task automatic drain();
      int          s;
      string       t;
      logic [63:0] e;
      #1;
      while (q_sel.size() > 0) begin
         s = q_sel.pop_front();
         t = q_tag.pop_front();
         e = q_exp.pop_front();
         check(t, observe(s), e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we     = 1'b0;
      rsv_en = 1'b0;
   endtask

   task automatic set_ra(
      input logic [AW-1:0] a0,
      input logic [AW-1:0] a1
   );
      ra = {a1, a0};
   endtask

   initial begin
      idle();
      wa       = '0;
      wd       = '0;
      rsv_addr = '0;
      set_ra(5'd0, 5'd0);
      #1 rst_n = 1'b0;
      push(S_RD0,  "rst_rd0",  64'h0);
      push(S_RD1,  "rst_rd1",  64'h0);
      push(S_BUSY, "rst_busy", 64'h0);
      push(S_PEND, "rst_pend", 64'h0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      cyc();
      idle();
      set_ra(5'd5, 5'd5);
      push(S_RD0, "r5_p0", 64'hDEADBEEF);
      push(S_RD1, "r5_p1", 64'hDEADBEEF);
      drain();

      we = 1'b1; wa = 5'd0; wd = 32'h1234;
      cyc();
      idle();
      set_ra(5'd0, 5'd5);
      push(S_RD0,  "r0_rd",   64'h0);
      push(S_BUSY, "r0_busy", 64'h0);
      drain();

      rsv_en = 1'b1; rsv_addr = 5'd7;
      cyc();
      idle();
      set_ra(5'd7, 5'd0);
      push(S_BUSY, "r7_rsv_busy", 64'h1);
      push(S_PEND, "r7_rsv_pend", 64'h1);
      drain();

      we = 1'b1; wa = 5'd7; wd = 32'hA5;
      cyc();
      idle();
      push(S_RD0,  "r7_wb_rd",   64'hA5);
      push(S_BUSY, "r7_wb_busy", 64'h0);
      push(S_PEND, "r7_wb_pend", 64'h0);
      drain();

      we = 1'b1; wa = 5'd9; wd = 32'h55;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      cyc();
      idle();
      set_ra(5'd0, 5'd9);
      push(S_RD1,  "r9_same_rd",   64'h55);
      push(S_BUSY, "r9_same_busy", 64'h2);
      push(S_PEND, "r9_same_pend", 64'h1);
      drain();

      we = 1'b1; wa = 5'd9; wd = 32'h66;
      cyc();
      idle();
      push(S_RD1,  "r9_rel_rd",   64'h66);
      push(S_PEND, "r9_rel_pend", 64'h0);
      drain();

      we = 1'b1; wa = 5'd3; wd = 32'h11;
      cyc();
      idle();

      set_ra(5'd3, 5'd0);
      we = 1'b1; wa = 5'd3; wd = 32'h77;
`ifdef REGFILE_BYPASS_EN
      push(S_RD0, "byp_rd", 64'h77);
`else
      push(S_RD0, "byp_rd", 64'h11);
`endif
      push(S_BUSY, "byp_busy", 64'h0);
      drain();
      rsv_en = 1'b1; rsv_addr = 5'd3;
`ifdef REGFILE_BYPASS_EN
      push(S_BUSY, "byp_rsv_busy", 64'h1);
`else
      push(S_BUSY, "byp_rsv_busy", 64'h0);
`endif
      drain();
      cyc();
      idle();
      push(S_RD0,  "byp_post_rd",   64'h77);
      push(S_BUSY, "byp_post_busy", 64'h1);
      push(S_PEND, "byp_post_pend", 64'h1);
      drain();
      we = 1'b1; wa = 5'd3; wd = 32'h77;
      cyc();
      idle();
      push(S_PEND, "r3_rel_pend", 64'h0);
      drain();

      for (int i = 1; i < 32; i++) begin
         rsv_en   = 1'b1;
         rsv_addr = AW'(i);
         cyc();
         idle();
         push(S_PEND, $sformatf("fill_%0d", i),
              64'(i));
         drain();
      end

      rsv_en = 1'b1; rsv_addr = 5'd4;
      cyc();
      idle();
      push(S_PEND, "rersv_r4", 64'd31);
      drain();

      rsv_en = 1'b1; rsv_addr = 5'd0;
      cyc();
      idle();
      set_ra(5'd0, 5'd4);
      push(S_PEND, "rsv_r0_pend", 64'd31);
      push(S_BUSY, "rsv_r0_busy", 64'h2);
      drain();

      we = 1'b1; wa = 5'd4; wd = 32'h44;
      cyc();
      idle();
      push(S_PEND, "rel_r4_pend", 64'd30);
      push(S_BUSY, "rel_r4_busy", 64'h0);
      drain();

      we = 1'b1; wa = 5'd6; wd = 32'h6;
      rsv_en = 1'b1; rsv_addr = 5'd4;
      cyc();
      idle();
      set_ra(5'd6, 5'd4);
      push(S_PEND, "swap_pend", 64'd30);
      push(S_BUSY, "swap_busy", 64'h2);
      drain();

      set_ra(5'd5, 5'd7);
      push(S_RD0, "pre_rst_rd0", 64'hDEADBEEF);
      push(S_RD1, "pre_rst_rd1", 64'hA5);
      drain();
      #1 rst_n = 1'b0;
      push(S_RD0,  "mid_rst_rd0",  64'h0);
      push(S_RD1,  "mid_rst_rd1",  64'h0);
      push(S_BUSY, "mid_rst_busy", 64'h0);
      push(S_PEND, "mid_rst_pend", 64'h0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed",
               n_run, n_fail);
      $finish;
   end

endmodule
